// File: rtl/adder_pipe_stage.sv
// Valid/ready register wrapper around an external combinational 32-bit adder.
// Stage 1 holds operands driven to the adder; stage 2 captures sum, carry and flags.
module adder_pipe_stage #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic             in_cin,
    output logic [N-1:0]     add_a,
    output logic [N-1:0]     add_b,
    output logic             add_cin,
    input  logic [N-1:0]     add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [CNT_W-1:0] txn_count
);

    logic             r_s1_valid;
    logic             r_s2_valid;
    logic [N-1:0]     r_add_a;
    logic [N-1:0]     r_add_b;
    logic             r_add_cin;
    logic [N-1:0]     r_out_sum;
    logic             r_out_cout;
    logic             r_out_ovf;
    logic             r_out_zero;
    logic [CNT_W-1:0] r_txn_count;

    logic w_in_ready;
    logic w_in_fire;
    logic w_s1_adv;
    logic w_out_fire;
    logic w_ovf;
    logic w_zero;

    // Stage 1 may refill in the same edge it advances, giving one beat per cycle.
    assign w_s1_adv   = r_s1_valid & (~r_s2_valid | out_ready);
    assign w_in_ready = rst_n & (~r_s1_valid | w_s1_adv);
    assign w_in_fire  = in_valid & w_in_ready;
    assign w_out_fire = r_s2_valid & out_ready;

    assign w_ovf  = (r_add_a[N-1] == r_add_b[N-1]) & (add_sum[N-1] != r_add_a[N-1]);
    assign w_zero = (add_sum == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_add_a    <= '0;
            r_add_b    <= '0;
            r_add_cin  <= 1'b0;
        end else begin
            r_s1_valid <= w_in_fire | (r_s1_valid & ~w_s1_adv);
            if (w_in_fire) begin
                r_add_a   <= in_a;
                r_add_b   <= in_b;
                r_add_cin <= in_cin;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_out_sum  <= '0;
            r_out_cout <= 1'b0;
            r_out_ovf  <= 1'b0;
            r_out_zero <= 1'b0;
        end else begin
            r_s2_valid <= w_s1_adv | (r_s2_valid & ~out_ready);
            if (w_s1_adv) begin
                r_out_sum  <= add_sum;
                r_out_cout <= add_cout;
                r_out_ovf  <= w_ovf;
                r_out_zero <= w_zero;
            end
        end
    end

    // Counts accepted results; wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txn_count <= '0;
        end else if (w_out_fire) begin
            r_txn_count <= r_txn_count + CNT_W'(1);
        end
    end

    assign in_ready  = w_in_ready;
    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign add_cin   = r_add_cin;
    assign out_valid = r_s2_valid;
    assign out_sum   = r_out_sum;
    assign out_cout  = r_out_cout;
    assign out_ovf   = r_out_ovf;
    assign out_zero  = r_out_zero;
    assign txn_count = r_txn_count;

endmodule

// File: tb/tb_adder_pipe_stage.sv
// Scoreboard bench for adder_pipe_stage; the combinational adder is modelled here.
// Driver pushes expected results on each accepted beat, a monitor pops on each accepted output.
module tb_adder_pipe_stage;

    localparam int N     = 32;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic             in_cin;
    logic [N-1:0]     add_a;
    logic [N-1:0]     add_b;
    logic             add_cin;
    logic [N-1:0]     add_sum;
    logic             add_cout;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;
    logic [CNT_W-1:0] txn_count;

    int   checks;
    int   errors;
    int   exp_cnt;
    res_t sb[$];
    logic rand_ready;
    logic stalled;
    res_t saved;

    adder_pipe_stage #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero),
        .txn_count(txn_count)
    );

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
        res_t r;
        logic [N:0] full;
        full   = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
        r.sum  = full[N-1:0];
        r.cout = full[N];
        r.ovf  = (a[N-1] == b[N-1]) && (full[N-1] != a[N-1]);
        r.zero = (full[N-1:0] == '0);
        return r;
    endfunction

    // One cycle of input drive, entered and left at posedge+1.
    task automatic drive_cycle(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic c, input logic use_exp, input res_t exp_r,
                               output logic fired);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_cin   = c;
        @(negedge clk);
        fired = v & in_ready;
        if (fired) sb.push_back(use_exp ? exp_r : model(a, b, c));
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                        input logic use_exp, input res_t exp_r);
        logic f;
        int   n;
        n = 0;
        f = 1'b0;
        while (!f && n < 1000) begin
            drive_cycle(1'b1, a, b, c, use_exp, exp_r, f);
            n++;
        end
        in_valid = 1'b0;
        if (!f) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: beat never accepted, in_ready=%0b", in_ready);
        end
    endtask

    task automatic send_exp(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                            input logic [N-1:0] s, input logic co, input logic ov, input logic z);
        res_t r;
        r.sum = s; r.cout = co; r.ovf = ov; r.zero = z;
        send(a, b, c, 1'b1, r);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding", sb.size());
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: counter, stall stability and ordered result comparison.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            check("txn_count", 64'(txn_count), 64'(exp_cnt[CNT_W-1:0]));
            if (stalled) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_payload", 64'({out_sum, out_cout, out_ovf, out_zero}), 64'(saved));
            end
            stalled = out_valid & ~out_ready;
            saved   = {out_sum, out_cout, out_ovf, out_zero};
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: sum=0x%0h with empty scoreboard", out_sum);
                end else begin
                    res_t e;
                    e = sb.pop_front();
                    check("result", 64'({out_sum, out_cout, out_ovf, out_zero}), 64'(e));
                end
                exp_cnt++;
            end
        end
    end

    initial begin
        logic f;
        int   base;
        res_t dummy;
        checks     = 0;
        errors     = 0;
        exp_cnt    = 0;
        stalled    = 1'b0;
        rand_ready = 1'b0;
        dummy      = '0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_cin     = 1'b0;
        out_ready  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_txn", 64'(txn_count), 64'd0);
        check("rst_add_a", 64'(add_a), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Single beat with latency check
        out_ready = 1'b1;
        send_exp(32'h5, 32'h3, 1'b0, 32'h8, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("lat_edge1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_edge2_valid", 64'(out_valid), 64'd1);
        check("lat_sum", 64'(out_sum), 64'h8);
        @(posedge clk);
        #1;
        check("txn_after_first", 64'(txn_count), 64'd1);

        // Carry, zero and overflow corners
        send_exp(32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        send_exp(32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        send_exp(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        send_exp(32'h0, 32'h0, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
        send_exp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        send_exp(32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0, 1'b0);
        drain();

        // Full-rate stream: every cycle must be accepted
        base = exp_cnt;
        for (int i = 0; i < 100; i++) begin
            drive_cycle(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, dummy, f);
            check("full_rate_fire", 64'(f), 64'd1);
        end
        in_valid = 1'b0;
        drain();
        check("stream_txn", 64'(txn_count), 64'(CNT_W'(base + 100)));

        // Backpressure: exactly two beats fit while output is stalled
        out_ready = 1'b0;
        base = 0;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 32'h100 + 32'(i), 32'h10, 1'b0, 1'b0, dummy, f);
            if (f) base++;
        end
        check("bp_accepted", 64'(base), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Random valid/ready toggling
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            while ($urandom_range(0, 1) == 0) drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, dummy, f);
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, dummy);
        end
        drain();
        rand_ready = 1'b0;
        #2;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset with both stages full
        out_ready = 1'b0;
        drive_cycle(1'b1, 32'hAAAA, 32'h1, 1'b0, 1'b0, dummy, f);
        drive_cycle(1'b1, 32'hBBBB, 32'h1, 1'b0, 1'b0, dummy, f);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_txn", 64'(txn_count), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        sb.delete();
        exp_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_exp(32'h10, 32'h20, 1'b0, 32'h30, 1'b0, 1'b0, 1'b0);
        drain();
        check("post_rst_txn", 64'(txn_count), 64'd1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_pipe_stage.md
Name: adder_pipe_stage

Overview:
Registered valid/ready wrapper that sits on both sides of the 32-bit combinational carry-skip adder.
- Upstream side: captures operands into an operand register and drives them to the adder.
- Downstream side: captures the adder's sum/carry into a result register with status flags and a transaction count.
- Gives the combinational adder a clean register-to-register timing path and a backpressure-capable stream interface.

Parameters:
N, 32, operand/sum width; must match the adder instance.
CNT_W, 16, width of the completed-transaction counter.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operand beat valid.
in_ready  output  1  stage can accept an operand beat.
in_a  input  N  operand A.
in_b  input  N  operand B.
in_cin  input  1  carry in.
add_a  output  N  operand A to adder (operand register).
add_b  output  N  operand B to adder (operand register).
add_cin  output  1  carry in to adder (operand register).
add_sum  input  N  sum returned from adder (combinational).
add_cout  input  1  carry out returned from adder.
out_valid  output  1  result beat valid.
out_ready  input  1  consumer accepts result.
out_sum  output  N  registered sum.
out_cout  output  1  registered carry out.
out_ovf  output  1  signed overflow of the registered result.
out_zero  output  1  registered sum == 0.
txn_count  output  CNT_W  number of results accepted downstream.

Behaviour:
Reset:
- rst_n low asynchronously clears s1_valid, s2_valid, add_a/add_b/add_cin, out_sum/out_cout/out_ovf/out_zero and txn_count to 0.
- in_ready = 1 is combinational from empty stages. While rst_n is low, in_ready is forced to 0.
- A reset asserted mid-operation discards all in-flight beats. No partial results appear after release.

Stage 1 (operand register):
- in_fire = in_valid & in_ready.
- On in_fire, add_a/add_b/add_cin load in_a/in_b/in_cin and s1_valid is set.
- Operand registers hold their value when no load occurs; they are never cleared except by reset.

Stage 2 (result register):
- s1_adv = s1_valid & (!s2_valid | out_ready).
- On s1_adv:
  - out_sum <= add_sum; out_cout <= add_cout; out_zero <= (add_sum == 0).
  - out_ovf <= (add_a[N-1] == add_b[N-1]) & (add_sum[N-1] != add_a[N-1]).
  - s2_valid is set.
- out_valid = s2_valid.

Handshake and ready:
- in_ready = !s1_valid | s1_adv. This gives full throughput: one beat per cycle with out_ready held high.
- s1_valid next = in_fire | (s1_valid & !s1_adv).
- s2_valid next = s1_adv | (s2_valid & !out_ready).
- Payload stability: while out_valid & !out_ready, out_* hold stable. While s1_valid & !s1_adv, add_* hold stable.

Latency:
- A beat accepted at clock edge k is in stage 1 during cycle k..k+1.
- It appears on out_* with out_valid = 1 after edge k+1. Latency is 2 edges.

Counter:
- txn_count increments by 1 on each out_valid & out_ready edge.
- Wraps from 2^CNT_W−1 to 0 with no flag.

Boundary conditions:
- Both stages full with out_ready low: in_ready = 0. No beat is lost or duplicated.
- Simultaneous drain and fill: with out_ready high and in_valid high while both stages are full, all three moves happen in the same edge (s2 drains, s1 advances, new beat loads).
- in_valid dropping mid-stream creates a bubble. out_valid deasserts for exactly one cycle, two edges later.
- in_a/in_b/in_cin are sampled only on in_fire. Values while in_ready = 0 are ignored.
- Arithmetic is unsigned mod 2^N; out_cout carries bit N. out_ovf interprets operands as two's complement.

Test Plan:
1. Reset then single beat: in_a=0x0000_0005, in_b=0x0000_0003, cin=0 → out_valid two edges later, out_sum=0x8, cout=0, ovf=0, zero=0; txn_count=1 after accept.
2. Carry/zero/overflow: A=0xFFFF_FFFF, B=0x0000_0001, cin=0 → sum=0, cout=1, zero=1, ovf=0. Then A=0x7FFF_FFFF, B=1 → sum=0x8000_0000, cout=0, ovf=1.
3. Full-rate stream: 100 random beats back-to-back with out_ready=1 → in_ready constantly 1, results in order, each equal to A+B+cin, txn_count=100.
4. Backpressure: out_ready=0 for 5 cycles while in_valid=1 → exactly 2 beats accepted, then in_ready=0. out_* stable during the stall. On release, beats drain in order with none lost.
5. Random in_valid/out_ready toggling (50% each) over 1000 beats → scoreboard matches a reference model; no duplicates or drops.
6. Reset mid-stream: assert rst_n=0 asynchronously with both stages full → out_valid and txn_count drop to 0 immediately. After release, first output corresponds to the first post-reset beat.
